// File: rtl/instr_fetch_responder.sv
// rtl/instr_fetch_responder.sv - fixed-latency instruction fetch responder with byte load port and one-word buffer
module instr_fetch_responder #(
    parameter int MEM_BYTES    = 1024,
    parameter int READ_LATENCY = 4
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic [31:0]                  PC,
    input  logic                         READ,
    output logic [31:0]                  INSTRUCTION,
    output logic                         BUSYWAIT,
    input  logic                         LOAD_EN,
    input  logic [$clog2(MEM_BYTES)-1:0] LOAD_ADDR,
    input  logic [7:0]                   LOAD_DATA
);

    localparam int AW    = $clog2(MEM_BYTES);
    localparam int WAW   = (AW > 2) ? AW - 2 : 1;
    localparam int WORDS = MEM_BYTES / 4;
    localparam int CW    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(READ_LATENCY - 1);

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WAW-1:0]  buf_wa_q, buf_wa_d;
    logic            valid_q, valid_d;
    logic [31:0]     instr_q, instr_d;
    logic            busy_q, busy_d;

    logic [WAW-1:0]  pc_wa;
    logic [WAW-1:0]  ld_wa;
    logic [1:0]      ld_lane;
    logic            ld_hits_buf;
    logic [31:0]     fetch_word;

    // Stored as little-endian words so a fetch is one array read.
    logic [31:0]     mem_q [WORDS];

    generate
        if (AW > 2) begin : g_wa
            logic unused_pc;
            assign pc_wa     = PC[AW-1:2];
            assign ld_wa     = LOAD_ADDR[AW-1:2];
            assign unused_pc = ^{PC[31:AW], PC[1:0]};
        end else begin : g_wa_single
            logic unused_pc;
            assign pc_wa     = '0;
            assign ld_wa     = '0;
            assign unused_pc = ^PC;
        end
    endgenerate

    assign ld_lane     = LOAD_ADDR[1:0];
    assign ld_hits_buf = LOAD_EN && (ld_wa == buf_wa_q);

    always_ff @(posedge CLK) begin
        if (LOAD_EN) begin
            mem_q[ld_wa][{ld_lane, 3'b000} +: 8] <= LOAD_DATA;
        end
    end

    // A byte written on the completion edge is merged into the returned word.
    always_comb begin
        fetch_word = mem_q[buf_wa_q];
        if (ld_hits_buf) begin
            fetch_word[{ld_lane, 3'b000} +: 8] = LOAD_DATA;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        buf_wa_d = buf_wa_q;
        valid_d  = valid_q;
        instr_d  = instr_q;
        busy_d   = busy_q;
        case (state_q)
            IDLE: begin
                if (READ && !(valid_q && (pc_wa == buf_wa_q))) begin
                    buf_wa_d = pc_wa;
                    cnt_d    = CNT_INIT;
                    busy_d   = 1'b1;
                    valid_d  = 1'b0;
                    state_d  = FETCH;
                end else if (ld_hits_buf) begin
                    valid_d = 1'b0;
                end
            end
            FETCH: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    instr_d = fetch_word;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            buf_wa_q <= '0;
            valid_q  <= 1'b0;
            instr_q  <= 32'h0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            buf_wa_q <= buf_wa_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            busy_q   <= busy_d;
        end
    end

    assign INSTRUCTION = instr_q;
    assign BUSYWAIT    = busy_q;

endmodule

// File: doc/instr_fetch_responder.md
# instr_fetch_responder

Instruction-fetch responder that sits on the other end of the CPU's fetch interface. It takes the CPU's program-counter fetch requests and returns 32-bit instruction words from an internal byte-addressed instruction memory after a fixed multi-cycle latency. While a fetch is in progress it stalls the requester with BUSYWAIT. A byte-wide load port fills the memory before or during execution, and a one-word buffer returns a repeat fetch of the same word with no stall.

## Interface
- MEM_BYTES, 1024: instruction memory size in bytes; power of two, at least 4.
- READ_LATENCY, 4: fetch latency in cycles; must be at least 1.
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- PC  in  32  byte address of the requested instruction.
- READ  in  1  fetch request; must be held, with PC stable, while BUSYWAIT=1.
- INSTRUCTION  out  32  fetched instruction word, registered.
- BUSYWAIT  out  1  stall to requester; 1 while a fetch is outstanding, registered.
- LOAD_EN  in  1  byte write enable for the load port.
- LOAD_ADDR  in  log2(MEM_BYTES)  byte address to write.
- LOAD_DATA  in  8  byte to write.

## Operation
- Word address WA = PC[log2(MEM_BYTES)-1:2].
  - PC[1:0] are ignored.
  - Upper PC bits are ignored, so addresses wrap modulo MEM_BYTES.
- Word assembly is little-endian: INSTRUCTION = {mem[4WA+3], mem[4WA+2], mem[4WA+1], mem[4WA]}. Opcode is the byte at the lowest address.
- State machine has two states, IDLE and FETCH.
  - IDLE, READ=1, VALID=1, and WA equals the buffered address BUF_WA: hit. No state change, BUSYWAIT stays 0, INSTRUCTION unchanged.
  - IDLE, READ=1, otherwise: miss.
    - Latch BUF_WA ← WA.
    - Load counter CNT ← READ_LATENCY-1.
    - Set BUSYWAIT ← 1, VALID ← 0.
    - Go to FETCH.
  - FETCH, CNT≠0: CNT ← CNT-1.
  - FETCH, CNT=0: completion.
    - Read the memory word at BUF_WA at this edge.
    - Set INSTRUCTION ← word, VALID ← 1, BUSYWAIT ← 0.
    - Go to IDLE.
  - IDLE, READ=0: hold all outputs.
- PC and READ are not re-sampled during FETCH. Changing them mid-fetch has no effect on the fetch in progress.
- Load port:
  - When LOAD_EN=1, mem[LOAD_ADDR] ← LOAD_DATA at the edge, in any state.
  - If LOAD_ADDR[..:2] equals BUF_WA while in IDLE, VALID ← 0, so the next fetch of that word misses.
  - A load during FETCH to BUF_WA is visible to that fetch if it occurs at or before the completion edge. At the completion edge the written byte is forwarded.
- Memory contents are not cleared by reset; they are undefined until loaded.

## Timing
- Reset (RESET=0, asynchronous) sets:
  - INSTRUCTION=32'h0, BUSYWAIT=0, state=IDLE, VALID=0, CNT=0, BUF_WA=0.
- Reset asserted mid-fetch aborts the fetch immediately, without waiting for a clock edge.
- Release of reset is synchronous in effect: the first request is sampled at the first rising edge with RESET=1.
- Miss sampled at edge k:
  - BUSYWAIT=1 from edge k through edge k+READ_LATENCY.
  - INSTRUCTION updates and BUSYWAIT falls together at edge k+READ_LATENCY.
  - The stall is therefore exactly READ_LATENCY cycles.
- Hit: zero stall; INSTRUCTION already holds the word.
- Back-to-back misses: a new miss can be sampled at the edge after completion. The minimum request period is READ_LATENCY+1 cycles.
- A simultaneous load and miss to the same word at edge k are both accepted. The fetch returns the updated byte.

## Test plan
- Reset behaviour: assert RESET=0 during a fetch of PC=0x10 at CNT=2 → BUSYWAIT and INSTRUCTION drop to 0 immediately. After release, a fetch of PC=0x10 takes the full 4 cycles.
- Basic fetch: load bytes 0x02,0x03,0x01,0x05 at 0x20..0x23, then READ with PC=0x20 → BUSYWAIT=1 for 4 cycles, then INSTRUCTION=32'h05010302 with BUSYWAIT=0.
- Hit and ignored offset bits: after the basic fetch, keep READ=1 and change PC to 0x23 → no BUSYWAIT; INSTRUCTION stays 32'h05010302.
- Load invalidation and forwarding:
  - After a hit, LOAD_EN writes 0xAA to 0x21, then READ PC=0x20 → miss, 4-cycle stall, INSTRUCTION=32'h0501AA02.
  - Repeat with the write issued mid-fetch → same result.
- Wrap-around: with MEM_BYTES=1024, load 0x11223344 at 0x3FC, fetch PC=0x7FC → 4-cycle stall, INSTRUCTION=32'h11223344.
- Back-to-back misses: fetch PC=0x00 then PC=0x04 with READ held high → two 4-cycle stalls separated by exactly one cycle with BUSYWAIT=0. With READ_LATENCY=1, the stall is 1 cycle.
